// File: rtl/dataload_pkg.sv
// Shared types and default geometry for the data-load sequencer.
package dataload_pkg;

    localparam int unsigned DEFAULT_BEATS   = 8;
    localparam int unsigned DEFAULT_IN_ROWS = 16;
    localparam int unsigned DEFAULT_W_ROWS  = 2;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } state_e;

    typedef enum logic {
        LD_WEIGHT = 1'b0,
        LD_INPUT  = 1'b1
    } load_type_e;

endpackage

// File: rtl/dl_counter.sv
// Modulo counter with synchronous clear, parallel load and a same-cycle wrap flag.
module dl_counter #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned MODULO = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

    // Flags the increment that takes the counter from MAX back to 0.
    assign wrap = en & (count == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dataload_sequencer.sv
// Streams source beats into the weight or input buffer bank and reports load completion.
module dataload_sequencer
    import dataload_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BEATS   = DEFAULT_BEATS,
    parameter int unsigned IN_ROWS = DEFAULT_IN_ROWS,
    parameter int unsigned W_ROWS  = DEFAULT_W_ROWS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic                       load_type_i,
    input  logic                       clear_i,
    input  logic                       src_valid_i,
    input  logic [DATA_W-1:0]          src_data_i,
    output logic                       src_ready_o,
    output logic                       buf_we_o,
    output logic                       buf_sel_o,
    output logic [$clog2(IN_ROWS)-1:0] buf_row_o,
    output logic [$clog2(BEATS)-1:0]   buf_beat_o,
    output logic [DATA_W-1:0]          buf_data_o,
    output logic                       weight_valid_o,
    output logic                       input_valid_o,
    output logic [$clog2(IN_ROWS)-1:0] input_load_num_o,
    output logic                       last_row_o,
    output logic                       busy_o
);

    localparam int unsigned BEAT_W = $clog2(BEATS);
    localparam int unsigned ROW_W  = $clog2(IN_ROWS);
    localparam logic [ROW_W-1:0] LAST_W_ROW = ROW_W'(W_ROWS - 1);

    state_e     state_q;
    load_type_e type_q;
    load_type_e req_type;

    logic             in_load;
    logic             transfer;
    logic             start_acc;
    logic             last_xfer;
    logic [BEAT_W-1:0] beat_q;
    logic [ROW_W-1:0]  row_q;
    logic [ROW_W-1:0]  num_q;
    logic [ROW_W-1:0]  row_start;
    logic              beat_wrap;
    logic              row_wrap_unused;
    logic              num_wrap;

    assign req_type  = load_type_e'(load_type_i);
    assign in_load   = (state_q == StLoad);
    assign transfer  = src_valid_i & in_load;
    assign start_acc = (state_q == StIdle) & start_i & ~clear_i;

    // Weight loads span W_ROWS rows from row 0; an input load is exactly one row.
    assign last_xfer = transfer & beat_wrap & ((type_q == LD_INPUT) | (row_q == LAST_W_ROW));
    assign row_start = (req_type == LD_INPUT) ? num_q : '0;

    assign src_ready_o      = in_load;
    assign buf_we_o         = transfer;
    assign buf_sel_o        = type_q;
    assign buf_row_o        = row_q;
    assign buf_beat_o       = beat_q;
    assign buf_data_o       = src_data_i;
    assign input_load_num_o = num_q;

    dl_counter #(
        .WIDTH  (BEAT_W),
        .MODULO (BEATS)
    ) u_beat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clear_i | start_acc),
        .load     (1'b0),
        .load_val ('0),
        .en       (transfer),
        .count    (beat_q),
        .wrap     (beat_wrap)
    );

    dl_counter #(
        .WIDTH  (ROW_W),
        .MODULO (IN_ROWS)
    ) u_row_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clear_i),
        .load     (start_acc),
        .load_val (row_start),
        .en       (transfer & beat_wrap),
        .count    (row_q),
        .wrap     (row_wrap_unused)
    );

    dl_counter #(
        .WIDTH  (ROW_W),
        .MODULO (IN_ROWS)
    ) u_num_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clear_i),
        .load     (1'b0),
        .load_val ('0),
        .en       (last_xfer & (type_q == LD_INPUT)),
        .count    (num_q),
        .wrap     (num_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            type_q         <= LD_WEIGHT;
            weight_valid_o <= 1'b0;
            input_valid_o  <= 1'b0;
            last_row_o     <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            weight_valid_o <= 1'b0;
            input_valid_o  <= 1'b0;
            last_row_o     <= 1'b0;
            if (clear_i) begin
                state_q <= StIdle;
                busy_o  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            state_q <= StLoad;
                            type_q  <= req_type;
                            busy_o  <= 1'b1;
                        end
                    end
                    StLoad: begin
                        if (last_xfer) begin
                            state_q        <= StDone;
                            weight_valid_o <= (type_q == LD_WEIGHT);
                            input_valid_o  <= (type_q == LD_INPUT);
                            last_row_o     <= (type_q == LD_INPUT) & num_wrap;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy_o  <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dataload_sequencer.sv
// Scoreboard bench: stimulus queues expected buffer writes and completion pulses, a monitor checks them.
module tb_dataload_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        load_type_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        src_valid_i = 1'b0;
    logic [31:0] src_data_i = '0;
    logic        src_ready_o;
    logic        buf_we_o;
    logic        buf_sel_o;
    logic [3:0]  buf_row_o;
    logic [2:0]  buf_beat_o;
    logic [31:0] buf_data_o;
    logic        weight_valid_o;
    logic        input_valid_o;
    logic [3:0]  input_load_num_o;
    logic        last_row_o;
    logic        busy_o;

    dataload_sequencer #(
        .DATA_W  (32),
        .BEATS   (8),
        .IN_ROWS (16),
        .W_ROWS  (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start_i),
        .load_type_i      (load_type_i),
        .clear_i          (clear_i),
        .src_valid_i      (src_valid_i),
        .src_data_i       (src_data_i),
        .src_ready_o      (src_ready_o),
        .buf_we_o         (buf_we_o),
        .buf_sel_o        (buf_sel_o),
        .buf_row_o        (buf_row_o),
        .buf_beat_o       (buf_beat_o),
        .buf_data_o       (buf_data_o),
        .weight_valid_o   (weight_valid_o),
        .input_valid_o    (input_valid_o),
        .input_load_num_o (input_load_num_o),
        .last_row_o       (last_row_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sel;
        logic [3:0]  row;
        logic [2:0]  beat;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic       is_input;
        logic [3:0] num;
        logic       last;
    } ev_t;

    wr_t wq[$];
    ev_t vq[$];
    int  checks = 0;
    int  failures = 0;
    int  num_model = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every buffer write and completion pulse must match the head of its queue.
    always @(negedge clk) begin
        wr_t w;
        ev_t v;
        if (buf_we_o === 1'b1) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", {63'd0, buf_we_o}, 64'd0);
            end else begin
                w = wq.pop_front();
                chk("write", {24'd0, buf_sel_o, buf_row_o, buf_beat_o, buf_data_o}, {24'd0, w});
            end
        end
        if ((weight_valid_o | input_valid_o) === 1'b1) begin
            if (vq.size() == 0) begin
                chk("unexpected_valid", {62'd0, weight_valid_o, input_valid_o}, 64'd0);
            end else begin
                v = vq.pop_front();
                chk("valid", {57'd0, input_valid_o, weight_valid_o, input_load_num_o, last_row_o},
                    {57'd0, v.is_input, ~v.is_input, v.num, v.last});
            end
        end else if (last_row_o !== 1'b0) begin
            chk("stray_last_row", {63'd0, last_row_o}, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete load; toggle inserts an idle source cycle after each beat, start_during
    // holds start_i high through LOAD and DONE to show it is ignored.
    task automatic do_load(input logic typ, input bit toggle, input bit start_during);
        int   total;
        int   sent;
        int   base;
        bit   v;
        wr_t  w;
        ev_t  e;
        total = typ ? 8 : 16;
        base  = typ ? num_model : 0;
        sent  = 0;
        v     = 1'b1;
        start_i     = 1'b1;
        load_type_i = typ;
        tick();
        start_i = start_during;
        while (sent < total) begin
            src_valid_i = v;
            src_data_i  = $urandom();
            if (v) begin
                w.sel  = typ;
                w.row  = 4'((base + sent / 8) % 16);
                w.beat = 3'(sent % 8);
                w.data = src_data_i;
                wq.push_back(w);
                if (sent == total - 1) begin
                    e.is_input = typ;
                    e.num      = typ ? 4'((num_model + 1) % 16) : 4'(num_model);
                    e.last     = typ && (num_model == 15);
                    vq.push_back(e);
                    if (typ) num_model = (num_model + 1) % 16;
                end
                sent++;
            end
            @(negedge clk);
            if (!v) chk("stall_no_write", {63'd0, buf_we_o}, 64'd0);
            tick();
            if (toggle) v = ~v;
        end
        src_valid_i = 1'b0;
        @(negedge clk);
        chk("done_pulse", {63'd0, typ ? input_valid_o : weight_valid_o}, 64'd1);
        chk("done_busy", {62'd0, busy_o, src_ready_o}, 64'd2);
        tick();
        start_i = 1'b0;
        @(negedge clk);
        chk("idle_after_done", {63'd0, busy_o}, 64'd0);
        tick();
    endtask

    // Weight or input load aborted by clear_i on beat index abort_at.
    task automatic do_clear(input logic typ, input int abort_at);
        wr_t w;
        start_i     = 1'b1;
        load_type_i = typ;
        tick();
        start_i = 1'b0;
        for (int i = 0; i <= abort_at; i++) begin
            src_valid_i = 1'b1;
            src_data_i  = $urandom();
            clear_i     = (i == abort_at);
            w.sel  = typ;
            w.row  = typ ? 4'(num_model) : 4'(i / 8);
            w.beat = 3'(i % 8);
            w.data = src_data_i;
            wq.push_back(w);
            tick();
        end
        clear_i = 1'b0;
        num_model = 0;
        @(negedge clk);
        chk("clear_busy", {63'd0, busy_o}, 64'd0);
        chk("clear_ready", {62'd0, src_ready_o, buf_we_o}, 64'd0);
        chk("clear_num", {60'd0, input_load_num_o}, 64'd0);
        chk("clear_no_pulse", {62'd0, weight_valid_o, input_valid_o}, 64'd0);
        tick();
        src_valid_i = 1'b0;
    endtask

    initial begin
        src_valid_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_ready_we", {62'd0, src_ready_o, buf_we_o}, 64'd0);
        chk("rst_pulses", {61'd0, weight_valid_o, input_valid_o, last_row_o}, 64'd0);
        chk("rst_num", {60'd0, input_load_num_o}, 64'd0);
        tick();
        rst_n       = 1'b1;
        src_valid_i = 1'b0;
        tick();

        do_load(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) do_load(1'b1, 1'b0, 1'b0);
        chk("num_wrapped", {60'd0, input_load_num_o}, 64'd0);
        do_load(1'b0, 1'b0, 1'b0);
        chk("weight_keeps_num", {60'd0, input_load_num_o}, 64'(num_model));
        do_load(1'b1, 1'b1, 1'b1);
        do_load(1'b1, 1'b0, 1'b0);

        do_clear(1'b0, 13);
        do_load(1'b0, 1'b0, 1'b0);
        do_load(1'b1, 1'b0, 1'b0);
        do_clear(1'b1, 7);

        do_load(1'b1, 1'b0, 1'b0);
        start_i     = 1'b1;
        load_type_i = 1'b1;
        tick();
        start_i = 1'b0;
        src_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src_data_i = $urandom();
            wq.push_back({1'b1, 4'(num_model), 3'(i), src_data_i});
            tick();
        end
        src_data_i = $urandom();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy_o}, 64'd0);
        chk("midrst_ready_we", {62'd0, src_ready_o, buf_we_o}, 64'd0);
        chk("midrst_num", {60'd0, input_load_num_o}, 64'd0);
        num_model = 0;
        tick();
        tick();
        rst_n       = 1'b1;
        src_valid_i = 1'b0;
        repeat (4) tick();
        do_load(1'b1, 1'b0, 1'b0);

        repeat (3) tick();
        chk("write_queue_drained", 64'(wq.size()), 64'd0);
        chk("valid_queue_drained", 64'(vq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
